// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours: hazard/redirect inputs,
// the instruction-memory port and the F/D register outputs.
interface fetch_stage_if #(
   parameter int IMEM_AW = 12
);
   logic               stall;
   logic               redirect;
   logic [31:0]        redirect_pc;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_q;
   logic [31:0]        pc;
   logic [31:0]        fd_instr;
   logic [31:0]        fd_pc;
   logic [31:0]        fd_pc_plus1;
   logic               fd_valid;
   logic [31:0]        instr_count;

   // The surrounding pipeline and instruction memory.
   modport master (
      output stall, redirect, redirect_pc, imem_q,
      input  imem_addr, pc, fd_instr, fd_pc, fd_pc_plus1, fd_valid, instr_count
   );

   // The fetch stage itself.
   modport slave (
      input  stall, redirect, redirect_pc, imem_q,
      output imem_addr, pc, fd_instr, fd_pc, fd_pc_plus1, fd_valid, instr_count
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with the F/D pipeline register: PC, load-use stall,
// execute-stage redirect flush and early j/jal redirect from F/D.
module fetch_stage #(
   parameter int IMEM_AW = 12
) (
   input logic          clock,
   input logic          reset,
   fetch_stage_if.slave bus
);
   localparam logic [4:0] OP_J   = 5'b00001;
   localparam logic [4:0] OP_JAL = 5'b00011;

   logic [31:0] pc_q, pc_d;
   logic [31:0] fd_instr_q, fd_instr_d;
   logic [31:0] fd_pc_q, fd_pc_d;
   logic [31:0] fd_pc_plus1_q, fd_pc_plus1_d;
   logic        fd_valid_q, fd_valid_d;
   logic [31:0] instr_count_q, instr_count_d;

   logic [31:0] pc_plus1;
   logic [31:0] jump_target;
   logic        early_j;

   assign pc_plus1    = pc_q + 32'd1;
   assign jump_target = {5'b0, fd_instr_q[26:0]};
   // A bubble can carry stale opcode bits only if fd_valid is dropped, so gate on it.
   assign early_j     = fd_valid_q &&
                        ((fd_instr_q[31:27] == OP_J) || (fd_instr_q[31:27] == OP_JAL));

   // Transfer contract: fd_valid marks a real instruction in F/D; stall acts as
   // "decode not ready", so F/D and pc hold while it is high unless a redirect
   // from an older instruction overrides it.
   always_comb begin
      pc_d          = pc_q;
      fd_instr_d    = fd_instr_q;
      fd_pc_d       = fd_pc_q;
      fd_pc_plus1_d = fd_pc_plus1_q;
      fd_valid_d    = fd_valid_q;
      instr_count_d = instr_count_q;

      if (fd_valid_q && !bus.stall) begin
         instr_count_d = instr_count_q + 32'd1;
      end

      if (bus.redirect) begin
         pc_d          = bus.redirect_pc;
         fd_instr_d    = 32'h0000_0000;
         fd_pc_d       = 32'h0000_0000;
         fd_pc_plus1_d = 32'h0000_0000;
         fd_valid_d    = 1'b0;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else if (early_j) begin
         pc_d          = jump_target;
         fd_instr_d    = 32'h0000_0000;
         fd_pc_d       = 32'h0000_0000;
         fd_pc_plus1_d = 32'h0000_0000;
         fd_valid_d    = 1'b0;
      end else begin
         pc_d          = pc_plus1;
         fd_instr_d    = bus.imem_q;
         fd_pc_d       = pc_q;
         fd_pc_plus1_d = pc_plus1;
         fd_valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q          <= 32'h0000_0000;
         fd_instr_q    <= 32'h0000_0000;
         fd_pc_q       <= 32'h0000_0000;
         fd_pc_plus1_q <= 32'h0000_0000;
         fd_valid_q    <= 1'b0;
         instr_count_q <= 32'h0000_0000;
      end else begin
         pc_q          <= pc_d;
         fd_instr_q    <= fd_instr_d;
         fd_pc_q       <= fd_pc_d;
         fd_pc_plus1_q <= fd_pc_plus1_d;
         fd_valid_q    <= fd_valid_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign bus.imem_addr   = pc_q[IMEM_AW-1:0];
   assign bus.pc          = pc_q;
   assign bus.fd_instr    = fd_instr_q;
   assign bus.fd_pc       = fd_pc_q;
   assign bus.fd_pc_plus1 = fd_pc_plus1_q;
   assign bus.fd_valid    = fd_valid_q;
   assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_stage;
   localparam int AW = 12;

   logic clock;
   logic reset;
   logic [31:0] imem [0:(1<<AW)-1];

   fetch_stage_if #(.IMEM_AW(AW)) bus ();

   fetch_stage #(.IMEM_AW(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.imem_q = imem[bus.imem_addr];

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- model state ----------------
   logic [31:0] m_pc, m_fi, m_fpc, m_fpc1, m_cnt;
   logic        m_fv;
   logic        chk_en;
   int          n_checks;
   int          n_errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected behaviour from the stage's rules, applied once per edge.
   task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      logic [4:0]  op;
      logic        is_jump;
      logic [31:0] fetched;
      if (r) begin
         m_pc = 0; m_fi = 0; m_fpc = 0; m_fpc1 = 0; m_fv = 0; m_cnt = 0;
      end else begin
         op      = m_fi[31:27];
         is_jump = m_fv && (op == 5'd1 || op == 5'd3);
         fetched = imem[m_pc[AW-1:0]];
         if (m_fv && !s) m_cnt = m_cnt + 1;
         if (rd) begin
            m_pc = rpc; m_fi = 0; m_fpc = 0; m_fpc1 = 0; m_fv = 0;
         end else if (s) begin
            // everything holds
         end else if (is_jump) begin
            m_pc = {5'b0, m_fi[26:0]}; m_fi = 0; m_fpc = 0; m_fpc1 = 0; m_fv = 0;
         end else begin
            m_fi = fetched; m_fpc = m_pc; m_fpc1 = m_pc + 1; m_fv = 1; m_pc = m_pc + 1;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      reset           = r;
      bus.stall       = s;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      @(posedge clock);
      model_edge(r, s, rd, rpc);
      @(negedge clock);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic fill_seq();
      for (int i = 0; i < (1<<AW); i++) imem[i] = 32'h1000_0000 + i;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (chk_en) begin
         chk("pc",          bus.pc,                  m_pc);
         chk("imem_addr",   {20'h0, bus.imem_addr},  {20'h0, m_pc[AW-1:0]});
         chk("fd_instr",    bus.fd_instr,            m_fi);
         chk("fd_pc",       bus.fd_pc,               m_fpc);
         chk("fd_pc_plus1", bus.fd_pc_plus1,         m_fpc1);
         chk("fd_valid",    {31'h0, bus.fd_valid},   {31'h0, m_fv});
         chk("instr_count", bus.instr_count,         m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      chk_en   = 1'b0;
      reset    = 1'b1;
      bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
      fill_seq();
      @(negedge clock);
      do_reset();
      do_reset();
      chk_en = 1'b1;
      chk("rst_pc",    bus.pc, 32'h0);
      chk("rst_valid", {31'h0, bus.fd_valid}, 32'h0);
      chk("rst_count", bus.instr_count, 32'h0);

      // Sequential fetch
      run(1);
      chk("seq_e1_instr", bus.fd_instr, 32'h1000_0000);
      run(4);
      chk("seq_e5_instr", bus.fd_instr, 32'h1000_0004);
      chk("seq_e5_pc",    bus.fd_pc, 32'd4);
      chk("seq_e5_pc1",   bus.fd_pc_plus1, 32'd5);
      chk("seq_e5_count", bus.instr_count, 32'd4);

      // Stall with imem[2] in F/D
      do_reset();
      run(3);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         chk("stall_instr", bus.fd_instr, 32'h1000_0002);
         chk("stall_fdpc",  bus.fd_pc, 32'd2);
         chk("stall_pc",    bus.pc, 32'd3);
         chk("stall_count", bus.instr_count, 32'd2);
      end
      run(1);
      chk("release_instr", bus.fd_instr, 32'h1000_0003);
      run(1);
      chk("pre_redir_pc", bus.pc, 32'd5);

      // Redirect
      step(1'b0, 1'b0, 1'b1, 32'h40);
      chk("redir_valid", {31'h0, bus.fd_valid}, 32'h0);
      chk("redir_instr", bus.fd_instr, 32'h0);
      chk("redir_pc",    bus.pc, 32'h40);
      run(1);
      chk("redir_tgt_instr", bus.fd_instr, 32'h1000_0040);
      chk("redir_tgt_pc",    bus.fd_pc, 32'h40);

      // Early jal
      imem[3] = 32'h1800_0020;
      do_reset();
      run(4);
      chk("jal_in_fd",  bus.fd_instr, 32'h1800_0020);
      chk("jal_link",   bus.fd_pc_plus1, 32'd4);
      run(1);
      chk("jal_bubble", {31'h0, bus.fd_valid}, 32'h0);
      chk("jal_pc",     bus.pc, 32'h20);
      run(1);
      chk("jal_tgt",    bus.fd_instr, 32'h1000_0020);
      imem[3] = 32'h1000_0003;

      // Priority collision: redirect + stall + j in F/D
      imem[5] = 32'h0800_0010;
      do_reset();
      run(6);
      chk("j_in_fd", bus.fd_instr, 32'h0800_0010);
      step(1'b0, 1'b1, 1'b1, 32'h80);
      chk("coll_pc",    bus.pc, 32'h80);
      chk("coll_valid", {31'h0, bus.fd_valid}, 32'h0);
      chk("coll_instr", bus.fd_instr, 32'h0);
      run(1);
      chk("coll_tgt",   bus.fd_instr, 32'h1000_0080);
      imem[5] = 32'h1000_0005;

      // Wrap, then reset during a stall
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      run(1);
      chk("wrap_fdpc", bus.fd_pc, 32'hFFFF_FFFF);
      chk("wrap_pc1",  bus.fd_pc_plus1, 32'h0);
      chk("wrap_pc",   bus.pc, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h123);
      chk("rst_stall_pc",    bus.pc, 32'h0);
      chk("rst_stall_valid", {31'h0, bus.fd_valid}, 32'h0);
      chk("rst_stall_count", bus.instr_count, 32'h0);
      chk("rst_stall_fdpc1", bus.fd_pc_plus1, 32'h0);

      // Randomized traffic with jumps sprinkled through memory
      for (int i = 0; i < (1<<AW); i++) begin
         imem[i] = $urandom;
         if ($urandom_range(0, 7) == 0)
            imem[i][31:27] = ($urandom_range(0, 1) == 0) ? 5'b00001 : 5'b00011;
         else if (imem[i][31:27] == 5'b00001 || imem[i][31:27] == 5'b00011)
            imem[i][31:27] = 5'b00010;
      end
      for (int i = 0; i < 3000; i++) begin
         logic        r, s, rd;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 99) == 0);
         s   = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = $urandom;
            1:       rpc = 32'hFFFF_FFFF - $urandom_range(0, 2);
            default: rpc = $urandom_range(0, (1<<AW)-1);
         endcase
         step(r, s, rd, rpc);
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
